dm_access_ctrl: RTL and testbench

CPU-side initiator for the data-memory port: takes one load/store per instruction from the MEM stage, drives a request/acknowledge transaction to the word-addressed data memory, and returns sign/zero-extended load data. It generates byte enables and lane-replicated write data for sb/sh/sw, and flags misaligned or out-of-range accesses without issuing them. It stalls the pipeline while a transaction is outstanding, so memories with variable latency are supported.

---
 rtl/dm_pkg.sv | 55 +++++
 rtl/dm_load_ext.sv | 27 ++
 rtl/dm_access_ctrl.sv | 134 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared opcode encoding, FSM states and store-side lane helpers for the
// data-memory access controller.
package dm_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_SW:   return 4'b1111;
            OP_SH:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << addr_lo;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [3:0] op, input logic [31:0] wdata);
        case (op)
            OP_SW:   return wdata;
            OP_SH:   return {2{wdata[15:0]}};
            OP_SB:   return {4{wdata[7:0]}};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load opcode.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator: validates one load/store, runs a req/ack handshake
// to the word-addressed data memory and returns the extended load result.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int MEM_BYTES = 12288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    output logic [31:0] m_pc,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] word_q, word_d;
    logic        rdata_valid_q, rdata_valid_d;

    logic bad_addr;
    logic accept;

    always_comb begin
        bad_addr = misaligned(op, addr[1:0]) || (addr >= MEM_LIMIT);
        exc_adel = op_valid && is_load(op) && bad_addr;
        exc_ades = op_valid && is_store(op) && bad_addr;
        // Gated by reset so that stall drops the instant reset is asserted.
        accept   = reset && op_valid && (is_load(op) || is_store(op)) && !bad_addr
                   && (state_q == ST_IDLE);
        stall    = accept || (state_q == ST_REQ);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        byteen_d      = byteen_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        we_d          = we_q;
        req_d         = req_q;
        op_d          = op_q;
        word_d        = word_q;
        rdata_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_REQ;
                    addr_d   = addr;
                    byteen_d = be_gen(op, addr[1:0]);
                    wdata_d  = wdata_rep(op, wdata);
                    pc_d     = pc;
                    we_d     = is_store(op);
                    op_d     = op;
                    req_d    = 1'b1;
                end
            end
            ST_REQ: begin
                if (m_ack) begin
                    state_d       = ST_DONE;
                    word_d        = m_rdata;
                    req_d         = 1'b0;
                    rdata_valid_d = !we_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 32'h0;
            byteen_q      <= 4'b0000;
            wdata_q       <= 32'h0;
            pc_q          <= 32'h0;
            we_q          <= 1'b0;
            req_q         <= 1'b0;
            op_q          <= OP_NONE;
            word_q        <= 32'h0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            byteen_q      <= byteen_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            we_q          <= we_d;
            req_q         <= req_d;
            op_q          <= op_d;
            word_q        <= word_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    dm_load_ext u_load_ext (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (word_q),
        .result  (rdata)
    );

    assign rdata_valid = rdata_valid_q;
    assign m_req       = req_q;
    assign m_we        = we_q;
    assign m_addr      = {addr_q[31:2], 2'b00};
    assign m_byteen    = byteen_q;
    assign m_wdata     = wdata_q;
    assign m_pc        = pc_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed and randomized bench for dm_access_ctrl with a word-array memory
// model that answers requests after a chosen latency.
module tb_dm_access_ctrl;

    localparam int MEM_BYTES = 12288;

    localparam logic [3:0] T_NONE = 4'd0;
    localparam logic [3:0] T_LW   = 4'd1;
    localparam logic [3:0] T_LH   = 4'd2;
    localparam logic [3:0] T_LHU  = 4'd3;
    localparam logic [3:0] T_LB   = 4'd4;
    localparam logic [3:0] T_LBU  = 4'd5;
    localparam logic [3:0] T_SW   = 4'd6;
    localparam logic [3:0] T_SH   = 4'd7;
    localparam logic [3:0] T_SB   = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic [31:0] m_pc;
    logic        m_ack;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int unsigned];

    always #5 clk = ~clk;

    dm_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .addr        (addr),
        .wdata       (wdata),
        .pc          (pc),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_byteen    (m_byteen),
        .m_wdata     (m_wdata),
        .m_pc        (m_pc),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = word;
        if (o == T_LH || o == T_LHU) begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
            if (o == T_LH && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
        end else if (o == T_LB || o == T_LBU) begin
            v = (word >> (8 * (a % 4))) & 32'h0000_00FF;
            if (o == T_LB && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    // One full pipeline transaction; lat = REQ cycles without ack before the ack cycle.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                         input int lat);
        logic        ld, st, bad;
        logic [31:0] pcv, rep, mask, exp_rd, word;
        logic [3:0]  be;
        int unsigned widx;
        ld  = (o >= 4'd1) && (o <= 4'd5);
        st  = (o >= 4'd6) && (o <= 4'd8);
        bad = (a >= MEM_BYTES)
              || ((o == T_LW || o == T_SW) && (a % 4 != 0))
              || ((o == T_LH || o == T_LHU || o == T_SH) && (a % 2 != 0));
        pcv = $urandom;
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; addr = a; wdata = w; pc = pcv; m_ack = 1'b0;
        #1;
        chk("exc_adel", 32'(exc_adel), 32'(ld && bad));
        chk("exc_ades", 32'(exc_ades), 32'(st && bad));
        chk("stall_accept", 32'(stall), 32'((ld || st) && !bad));
        if (!(ld || st) || bad) begin
            @(posedge clk); #1;
            chk("no_req", 32'(m_req), 32'd0);
            chk("no_stall", 32'(stall), 32'd0);
            op_valid = 1'b0;
            $display("op=%0d addr=%h not issued (adel=%0b ades=%0b)", o, a, ld && bad, st && bad);
            return;
        end
        be  = 4'b0000;
        rep = 32'h0;
        if (o == T_SW) begin be = 4'hF; rep = w; end
        if (o == T_SH) begin be = ((a % 4) == 2) ? 4'hC : 4'h3; rep = (w & 32'hFFFF) * 32'h0001_0001; end
        if (o == T_SB) begin be = 4'(1 << (a % 4)); rep = (w & 32'hFF) * 32'h0101_0101; end
        widx = a / 4;
        if (!mem.exists(widx)) mem[widx] = $urandom;
        word = mem[widx];
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            chk("req_held", 32'(m_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("m_addr", m_addr, widx * 4);
            chk("m_byteen", 32'(m_byteen), 32'(be));
            chk("m_we", 32'(m_we), 32'(st));
            chk("m_pc", m_pc, pcv);
            chk("rv_in_req", 32'(rdata_valid), 32'd0);
            if (st) chk("m_wdata", m_wdata, rep);
            if (k == lat) begin
                m_ack = 1'b1;
                m_rdata = word;
            end else begin
                m_rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        m_ack = 1'b0;
        m_rdata = $urandom;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(m_req), 32'd0);
        chk("done_rv", 32'(rdata_valid), 32'(ld));
        exp_rd = ref_load(o, a, word);
        if (ld) chk("rdata", rdata, exp_rd);
        if (st) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
            mem[widx] = (word & ~mask) | (rep & mask);
        end
        op_valid = 1'b0;
        $display("op=%0d addr=%h wdata=%h lat=%0d be=%b exp_rdata=%h", o, a, w, lat, be,
                 ld ? exp_rd : 32'h0);
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op = T_NONE; addr = 32'h0; wdata = 32'h0;
        pc = 32'h0; m_ack = 1'b0; m_rdata = 32'h0;
        @(posedge clk); #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(m_req), 32'd0);
        chk("rst_we", 32'(m_we), 32'd0);
        chk("rst_rv", 32'(rdata_valid), 32'd0);
        chk("rst_be", 32'(m_byteen), 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_pc", m_pc, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        mem[32'h20 / 4] = 32'h1234_80FF;
        do_op(T_SW,  32'h0000_0010, 32'hDEAD_BEEF, 0);
        do_op(T_SB,  32'h0000_0013, 32'h0000_00A5, 0);
        do_op(T_SH,  32'h0000_0012, 32'h0000_C3D2, 1);
        do_op(T_LW,  32'h0000_0010, 32'h0, 0);
        do_op(T_LB,  32'h0000_0021, 32'h0, 0);
        do_op(T_LBU, 32'h0000_0021, 32'h0, 2);
        do_op(T_LH,  32'h0000_0022, 32'h0, 0);
        do_op(T_LHU, 32'h0000_0020, 32'h0, 0);
        do_op(T_LW,  32'h0000_0006, 32'h0, 0);
        do_op(T_SW,  32'h0000_3000, 32'h1111_2222, 0);
        do_op(T_SW,  32'h0000_2FFC, 32'hCAFE_F00D, 0);
        do_op(T_SB,  32'h0000_2FFF, 32'h0000_0077, 0);
        do_op(T_SB,  32'h0000_3000, 32'h0000_0077, 0);
        do_op(T_LBU, 32'h0000_2FFF, 32'h0, 0);
        do_op(T_LH,  32'h0000_0023, 32'h0, 0);
        do_op(T_SH,  32'h0000_0011, 32'h0, 0);
        do_op(T_NONE, 32'h0000_0010, 32'h0, 0);
        do_op(4'd12, 32'h0000_0010, 32'h0, 0);
        do_op(T_LW,  32'h0000_0040, 32'h0, 4);

        // Reset in the second REQ cycle abandons the access; a stray ack afterwards is ignored.
        @(posedge clk); #1;
        op_valid = 1'b1; op = T_LW; addr = 32'h44; m_ack = 1'b0;
        #1 chk("mr_accept", 32'(stall), 32'd1);
        @(posedge clk); #1 chk("mr_req1", 32'(m_req), 32'd1);
        @(posedge clk); #1 chk("mr_req2", 32'(m_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_req_drop", 32'(m_req), 32'd0);
        chk("mr_stall_drop", 32'(stall), 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; reset = 1'b1; m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        chk("stray_req", 32'(m_req), 32'd0);
        chk("stray_stall", 32'(stall), 32'd0);
        chk("stray_rv", 32'(rdata_valid), 32'd0);
        @(posedge clk); #1;
        chk("stray_req2", 32'(m_req), 32'd0);
        $display("reset mid-transaction at addr=00000044 abandoned");

        for (int n = 0; n < 200; n++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            ro = 4'($urandom_range(0, 15));
            if (ro > 4'd8 && $urandom_range(0, 3) != 0) ro = 4'($urandom_range(1, 8));
            ra = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ra = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 8);
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (ro == T_LW || ro == T_SW) ra = ra & ~32'h3;
                if (ro == T_LH || ro == T_LHU || ro == T_SH) ra = ra & ~32'h1;
            end
            do_op(ro, ra, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
